// File: rtl/fetch_queue_if.sv
// Fetch front-end bus bundle.
// Groups the pipeline control inputs (halt/redirect), the instruction-memory
// request/response pair and the valid/ready output toward IF/ID.
//   slave  : the fetch_queue side (drives imem_req/addr and the out_* head)
//   master : the pipeline/memory side (drives halt, redirect, rdata, ready)
interface fetch_queue_if #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32,
    parameter int unsigned CNT_W = 3
);
    logic             halt;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [INS_W-1:0] out_instr;
    logic [CNT_W-1:0] count;

    modport slave (
        input  halt, redirect, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr, count
    );

    modport master (
        output halt, redirect, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end of the 5-stage RV32 pipeline.
// Owns the fetch PC, issues sequential word fetches to instruction memory
// (1-cycle read latency) and buffers responses in a DEPTH-entry prefetch FIFO
// that presents {pc, instr} to the IF/ID register with a valid/ready handshake.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : fetch_queue_if.slave
//            halt / redirect / redirect_pc  - pipeline control in
//            imem_req / imem_addr           - fetch request out
//            imem_rdata                     - instruction, 1 cycle after req
//            out_valid / out_ready          - head handshake toward ID
//            out_pc / out_instr             - head entry (0 when empty)
//            count                          - current FIFO occupancy
module fetch_queue #(
    parameter int unsigned PC_W     = 9,
    parameter int unsigned INS_W    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_queue_if.slave      bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  fetch_pc_q,  fetch_pc_d;
    logic [PC_W-1:0]  issued_pc_q, issued_pc_d;
    logic             inflight_q,  inflight_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    logic             credit_ok_c;
    logic             issue_c;
    logic             push_c;
    logic             pop_c;
    logic             valid_c;
    logic [PC_W-1:0]  redirect_tgt_c;
    entry_t           head_c;

    // Low address bits of the redirect target are architecturally ignored.
    logic redirect_pc_lsb_unused;
    assign redirect_pc_lsb_unused = ^bus.redirect_pc[1:0];

    // Credit: queued entries plus the outstanding response must leave room.
    assign credit_ok_c = (({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH));

    assign issue_c        = !reset && !bus.halt && !bus.redirect && credit_ok_c;
    assign valid_c        = (count_q != '0);
    assign push_c         = inflight_q && !bus.redirect;
    assign pop_c          = valid_c && bus.out_ready && !bus.redirect;
    assign redirect_tgt_c = {bus.redirect_pc[PC_W-1:2], 2'b00};
    assign head_c         = mem_q[rd_ptr_q];

    // Next-state: redirect flushes everything; otherwise pop/push/issue are independent.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end

        if (bus.redirect) begin
            fetch_pc_d = redirect_tgt_c;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue_c) begin
                fetch_pc_d  = fetch_pc_q + PC_W'(4);
                issued_pc_d = fetch_pc_q;
                inflight_d  = 1'b1;
            end
            if (push_c) begin
                mem_d[wr_ptr_q] = '{pc: issued_pc_q, instr: bus.imem_rdata};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset overrides redirect and discards in-flight data.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= PC_W'(RESET_PC);
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are only observed through count, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign bus.imem_req  = issue_c;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = valid_c;
    assign bus.out_pc    = valid_c ? head_c.pc    : '0;
    assign bus.out_instr = valid_c ? head_c.instr : '0;
    assign bus.count     = count_q;

    // The credit rule must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_c && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    fetch_queue_if #(.PC_W(9), .INS_W(32), .CNT_W(3)) bus ();

    fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [8:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Instruction memory: address-tagged words, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= tag(bus.imem_addr);
    end

    typedef struct {
        logic       rst;
        logic       halt;
        logic       redir;
        logic [8:0] rpc;
        logic       rdy;
        logic       req;
        logic [8:0] addr;
        logic       vld;
        logic [8:0] pc;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic rst, h, rd, input logic [8:0] rpc, input logic rdy,
                                input logic req, input logic [8:0] addr, input logic vld,
                                input logic [8:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.rst = rst; v.halt = h; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic req, input logic [8:0] addr,
                             input logic vld, input logic [8:0] pc, input logic [2:0] cnt);
        chk({name, ".imem_req"},  32'(bus.imem_req),  32'(req));
        chk({name, ".imem_addr"}, 32'(bus.imem_addr), 32'(addr));
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
        chk({name, ".out_pc"},    32'(bus.out_pc),    32'(pc));
        chk({name, ".out_instr"}, bus.out_instr,      vld ? tag(pc) : 32'h0);
        chk({name, ".count"},     32'(bus.count),     32'(cnt));
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic drive(input logic rst, h, rd, input logic [8:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.halt        = h;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.out_ready   = rdy;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic got4;
        nvec = 0;
        nerr = 0;
        reset = 1'b1;
        bus.halt = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        //            rst h rd rpc    rdy | req addr   vld pc     cnt
        tbl[0]  = mk(1, 0, 0, 9'h0,   1,   0, 9'd0,   0, 9'd0,   0);
        tbl[1]  = mk(0, 0, 0, 9'h0,   1,   1, 9'd0,   0, 9'd0,   0);
        tbl[2]  = mk(0, 0, 0, 9'h0,   1,   1, 9'd4,   0, 9'd0,   0);
        tbl[3]  = mk(0, 0, 0, 9'h0,   1,   1, 9'd8,   1, 9'd0,   1);
        tbl[4]  = mk(0, 0, 0, 9'h0,   1,   1, 9'd12,  1, 9'd4,   1);
        tbl[5]  = mk(0, 0, 0, 9'h0,   0,   1, 9'd16,  1, 9'd8,   1);
        tbl[6]  = mk(0, 0, 0, 9'h0,   0,   1, 9'd20,  1, 9'd8,   2);
        tbl[7]  = mk(0, 0, 0, 9'h0,   0,   0, 9'd24,  1, 9'd8,   3);
        tbl[8]  = mk(0, 0, 0, 9'h0,   0,   0, 9'd24,  1, 9'd8,   4);
        tbl[9]  = mk(0, 0, 0, 9'h0,   0,   0, 9'd24,  1, 9'd8,   4);
        tbl[10] = mk(0, 0, 0, 9'h0,   1,   0, 9'd24,  1, 9'd8,   4);
        tbl[11] = mk(0, 0, 0, 9'h0,   1,   1, 9'd24,  1, 9'd12,  3);
        tbl[12] = mk(0, 0, 0, 9'h0,   1,   1, 9'd28,  1, 9'd16,  2);
        tbl[13] = mk(0, 0, 0, 9'h0,   1,   1, 9'd32,  1, 9'd20,  2);
        tbl[14] = mk(0, 1, 0, 9'h0,   0,   0, 9'd36,  1, 9'd24,  2);
        tbl[15] = mk(0, 1, 0, 9'h0,   1,   0, 9'd36,  1, 9'd24,  3);
        tbl[16] = mk(0, 1, 0, 9'h0,   1,   0, 9'd36,  1, 9'd28,  2);
        tbl[17] = mk(0, 1, 0, 9'h0,   1,   0, 9'd36,  1, 9'd32,  1);
        tbl[18] = mk(0, 1, 0, 9'h0,   1,   0, 9'd36,  0, 9'd0,   0);
        tbl[19] = mk(0, 0, 0, 9'h0,   1,   1, 9'd36,  0, 9'd0,   0);
        tbl[20] = mk(0, 0, 0, 9'h0,   1,   1, 9'd40,  0, 9'd0,   0);
        tbl[21] = mk(0, 0, 1, 9'h043, 1,   0, 9'd44,  1, 9'd36,  1);
        tbl[22] = mk(0, 0, 0, 9'h0,   1,   1, 9'h040, 0, 9'd0,   0);
        tbl[23] = mk(0, 0, 0, 9'h0,   1,   1, 9'h044, 0, 9'd0,   0);
        tbl[24] = mk(0, 0, 0, 9'h0,   1,   1, 9'h048, 1, 9'h040, 1);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].rst, tbl[i].halt, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            chk_state($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].cnt);
        end

        // Redirect with 3 queued and 1 in flight: no stale push, target out 3 cycles later.
        drive(1, 0, 0, 9'h0, 0);
        drive(0, 0, 0, 9'h0, 0);  chk_state("rd3.c1", 1, 9'd0,  0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 0);  chk_state("rd3.c2", 1, 9'd4,  0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 0);  chk_state("rd3.c3", 1, 9'd8,  1, 9'd0, 1);
        drive(0, 0, 0, 9'h0, 0);  chk_state("rd3.c4", 1, 9'd12, 1, 9'd0, 2);
        drive(0, 0, 1, 9'h040, 0); chk_state("rd3.c5", 0, 9'd16, 1, 9'd0, 3);
        drive(0, 0, 0, 9'h0, 1);  chk_state("rd3.c6", 1, 9'h040, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("rd3.c7", 1, 9'h044, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("rd3.c8", 1, 9'h048, 1, 9'h040, 1);

        // Fetch PC wraps from 0x1FC to 0x000.
        drive(0, 0, 1, 9'h1FC, 1);
        drive(0, 0, 0, 9'h0, 1);  chk_state("wrap.c1", 1, 9'h1FC, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("wrap.c2", 1, 9'h000, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("wrap.c3", 1, 9'h004, 1, 9'h1FC, 1);
        drive(0, 0, 0, 9'h0, 1);  chk_state("wrap.c4", 1, 9'h008, 1, 9'h000, 1);

        // Fill to full, then redirect and pop together: pop ignored, queue empties.
        got4 = 1'b0;
        for (int k = 0; k < 8 && !got4; k++) begin
            drive(0, 0, 0, 9'h0, 0);
            if (bus.count == 3'd4) got4 = 1'b1;
        end
        chk("fill_full", 32'(got4), 32'd1);
        drive(0, 0, 1, 9'h100, 1);
        chk("rdpop.count_before", 32'(bus.count), 32'd4);
        drive(0, 0, 0, 9'h0, 1);  chk_state("rdpop.after", 1, 9'h100, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("rdpop.c2", 1, 9'h104, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("rdpop.c3", 1, 9'h108, 1, 9'h100, 1);

        // Reset mid-stream: request drops at once, state clears on the next cycle.
        drive(1, 0, 0, 9'h0, 1);
        chk("rst.req_now", 32'(bus.imem_req), 32'd0);
        drive(1, 0, 0, 9'h0, 1);  chk_state("rst.cleared", 0, 9'd0, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("rst.resume", 1, 9'd0, 0, 9'd0, 0);

        // Redirect while halted: flush and retarget, no fetch until halt drops.
        drive(0, 0, 0, 9'h0, 1);  chk_state("hr.c1", 1, 9'd4, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("hr.c2", 1, 9'd8, 1, 9'd0, 1);
        drive(0, 1, 1, 9'h083, 1);
        chk("hr.req_redirect", 32'(bus.imem_req), 32'd0);
        drive(0, 1, 0, 9'h0, 1);  chk_state("hr.halted1", 0, 9'h080, 0, 9'd0, 0);
        drive(0, 1, 0, 9'h0, 1);  chk_state("hr.halted2", 0, 9'h080, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("hr.release", 1, 9'h080, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("hr.c5", 1, 9'h084, 0, 9'd0, 0);
        drive(0, 0, 0, 9'h0, 1);  chk_state("hr.c6", 1, 9'h088, 1, 9'h080, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
